// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and access sequencer in front of the 16-bit,
// byte-addressed, little-endian data memory. Port P is the pipeline MEM stage,
// port L is the program/data loader. One requester is granted at a time. The
// arbiter drives a single registered memory access and returns a completion
// pulse, an error flag and read data to that requester.
//
// Build option: define DMEM_ARB_RR_EN to resolve simultaneous requests
// round-robin (the port not granted most recently wins). Without it, the
// arbiter uses fixed priority with P ahead of L.
module dmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  // pipeline port
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_done,
  output logic              p_err,
  output logic [DATA_W-1:0] p_rdata,
  // loader port
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_done,
  output logic              l_err,
  output logic [DATA_W-1:0] l_rdata,
  // memory side
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state;
  logic   gnt;     // 0 = P, 1 = L
  logic   err_q;   // current transaction was rejected as misaligned
  logic   rd_q;    // current transaction is a read

`ifdef DMEM_ARB_RR_EN
  logic   last_l;  // 1 = L was granted most recently
`endif

  logic              win_l;
  logic              any_req;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              resp;

  // Word accesses must sit on an even byte address.
  function automatic logic misaligned(input logic [ADDR_W-1:0] a);
    return a[0];
  endfunction

  // Pick the winner among the current requesters and mux its fields.
  always_comb begin
    win_l   = 1'b0;
    any_req = p_req | l_req;
    if (p_req && l_req) begin
`ifdef DMEM_ARB_RR_EN
      win_l = ~last_l;
`else
      win_l = 1'b0;
`endif
    end else begin
      win_l = l_req;
    end
    w_we    = win_l ? l_we    : p_we;
    w_addr  = win_l ? l_addr  : p_addr;
    w_wdata = win_l ? l_wdata : p_wdata;
  end

  // Access sequencer: sample in IDLE, strobe memory in ISSUE, respond in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      err_q     <= 1'b0;
      rd_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_l    <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          mem_we <= 1'b0;
          mem_re <= 1'b0;
          if (any_req) begin
            gnt       <= win_l;
            mem_addr  <= w_addr;
            mem_wdata <= w_wdata;
            rd_q      <= ~w_we;
`ifdef DMEM_ARB_RR_EN
            last_l    <= win_l;
`endif
            if (misaligned(w_addr)) begin
              // Rejected without a memory access; answer next cycle.
              err_q <= 1'b1;
              state <= RESP;
            end else begin
              err_q  <= 1'b0;
              mem_we <= w_we;
              mem_re <= ~w_we;
              state  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          mem_we <= 1'b0;
          mem_re <= 1'b0;
          state  <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          mem_we <= 1'b0;
          mem_re <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Response decode: only the granted port sees done/err/rdata.
  always_comb begin
    resp    = (state == RESP);
    p_done  = resp & ~gnt;
    l_done  = resp &  gnt;
    p_err   = p_done & err_q;
    l_err   = l_done & err_q;
    p_rdata = (p_done && !err_q && rd_q) ? mem_rdata : '0;
    l_rdata = (l_done && !err_q && rd_q) ? mem_rdata : '0;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the 16-bit, byte-addressed, little-endian data memory. It shares the memory between the pipeline MEM stage (port P) and the program/data loader port (port L). It grants one requester at a time and drives a single registered memory access. It returns read data and a completion pulse to the granted requester. Misaligned word accesses are rejected without touching memory.

## Interface
Parameters:
- ADDR_W, 16, byte address width
- DATA_W, 16, data word width (two bytes, low byte at even address)

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset; synchronous, active-high
- p_req  input  1  pipeline request; held with fields stable until p_done
- p_we  input  1  1 = write, 0 = read
- p_addr  input  ADDR_W  byte address
- p_wdata  input  DATA_W  write data
- p_done  output  1  one-cycle completion pulse
- p_err  output  1  valid with p_done; 1 = misaligned, no access made
- p_rdata  output  DATA_W  read data, valid while p_done=1 on a read
- l_req, l_we, l_addr, l_wdata, l_done, l_err, l_rdata: same as the p_* ports, for the loader
- mem_addr  output  ADDR_W  registered memory address
- mem_wdata  output  DATA_W  registered write data
- mem_we  output  1  write strobe, one cycle
- mem_re  output  1  read strobe, one cycle
- mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_re

## Operation
States: IDLE, ISSUE, RESP. Register `gnt` selects the port (0=P, 1=L).
- IDLE
  - No request: stay in IDLE.
  - Any request: pick the winner, latch `gnt`, and register mem_addr/mem_wdata from the winner.
  - Winner addr[0]=0: go to ISSUE and register mem_we=we, mem_re=~we.
  - Winner addr[0]=1: go to RESP with an error flag set. mem_we and mem_re stay 0.
- ISSUE: mem_we or mem_re is high for exactly this cycle. Next state is RESP. Strobes deassert.
- RESP
  - x_done=1 for the granted port only.
  - x_err is the error flag.
  - x_rdata = mem_rdata (passthrough) for a non-error read; otherwise 0.
  - Next state is IDLE.
- The non-granted port's done, err and rdata are 0 at all times.
- Requester rule: req must drop in the cycle after done, or it is taken as a new transaction.
  - Fields changing while req=1 and before done is a protocol violation. Behaviour is undefined; the bench must not do it.
- Arbitration (default): fixed priority, P beats L. L can starve while P requests back-to-back. This is accepted.
- Requests arriving in ISSUE or RESP are ignored until IDLE. No queueing.
- Address 0xFFFE: the access reaches bytes 0xFFFE/0xFFFF. No wrap check is made; that is the memory's responsibility.

## Timing
- Request sampled in IDLE at cycle N:
  - memory strobe in cycle N+1;
  - done, and read data, in cycle N+2;
  - IDLE again in cycle N+3.
- Misaligned request: done+err in cycle N+1, IDLE in cycle N+2.
- Maximum throughput is one aligned access per 3 cycles.
- Reset values:
  - state=IDLE, gnt=0;
  - mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0;
  - every done, err and rdata output is 0.
  - Round-robin last-grant register (if compiled in) resets to L, so P wins the first tie.
- rst asserted in any state:
  - next cycle is IDLE with all outputs at reset values;
  - an in-flight transaction is dropped and gets no done;
  - a write already strobed in ISSUE is not undone.
- Outputs mem_* are registered. x_done and x_err are decoded from state/gnt. x_rdata is combinational from mem_rdata.

## Configuration
- DMEM_ARB_RR_EN defined:
  - Round-robin on ties in IDLE: the port not granted most recently wins.
  - The last-grant register updates on every grant, including error grants.
  - A single requester is always granted immediately.
- Not defined: fixed priority P > L. No last-grant register exists.

## Test plan
- Aligned write then read, single port:
  - P writes 0xBEEF to 0x0010. mem_we is high in N+1 with mem_addr=0x0010, and p_done is high in N+2.
  - P then reads 0x0010. p_rdata=0xBEEF with p_done at N+2, and p_err=0.
- Misaligned access:
  - L reads 0x0021. l_done=1 and l_err=1 at N+1, l_rdata=0.
  - mem_re and mem_we are never asserted.
- Simultaneous requests, default build:
  - P reads 0x0004 while L writes 0x1234 to 0x0006, both raised at the same cycle.
  - P completes first, at N+2. L then completes at N+5, with mem_we at N+4.
- Simultaneous requests with DMEM_ARB_RR_EN, both held continuously for 4 transactions:
  - Grant order is P, L, P, L.
  - Without the macro, P holding requests keeps l_done at 0.
- Reset mid-operation:
  - Assert rst during ISSUE of a P read.
  - Next cycle all outputs are 0 and state is IDLE. p_done never pulses for that read.
  - A fresh P read afterwards completes at N+2.
- Late request ignored:
  - L raises req during P's ISSUE cycle.
  - L is sampled only when IDLE is re-entered. l_done appears 2 cycles after that, and there is no overlap with p_done.
